// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter that shares one single-read/single-write register file between
// two req/ack requesters; every granted access runs IDLE -> SERVE -> DONE -> IDLE.
module regfile_port_arbiter #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_num,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_num,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [DW-1:0] rf_data_in,
    output logic [AW-1:0] rf_writenum,
    output logic          rf_write,
    output logic [AW-1:0] rf_readnum,
    input  logic [DW-1:0] rf_data_out,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t        state_r;
    state_t        state_s;
    logic          last_grant_r;
    logic          op_port_r;
    logic          op_we_r;
    logic [AW-1:0] op_num_r;
    logic [DW-1:0] op_wdata_r;
    logic          rf_write_r;
    logic          a_ack_r;
    logic          b_ack_r;
    logic [DW-1:0] a_rdata_r;
    logic [DW-1:0] b_rdata_r;
    logic          busy_r;

    logic          grant_valid_s;
    logic          grant_port_s;
    logic          grant_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_num_s;
    logic [DW-1:0] sel_wdata_s;

    // Round-robin choice: on a tie the port that did not win last time is granted.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_port_s  = PORT_A;
        if (a_req && b_req) begin
            grant_valid_s = 1'b1;
            grant_port_s  = ~last_grant_r;
        end else if (a_req) begin
            grant_valid_s = 1'b1;
            grant_port_s  = PORT_A;
        end else if (b_req) begin
            grant_valid_s = 1'b1;
            grant_port_s  = PORT_B;
        end else begin
            grant_valid_s = 1'b0;
            grant_port_s  = PORT_A;
        end
    end

    // Operand mux for the port being granted this cycle.
    always_comb begin
        sel_we_s    = a_we;
        sel_num_s   = a_num;
        sel_wdata_s = a_wdata;
        if (grant_port_s == PORT_B) begin
            sel_we_s    = b_we;
            sel_num_s   = b_num;
            sel_wdata_s = b_wdata;
        end else begin
            sel_we_s    = a_we;
            sel_num_s   = a_num;
            sel_wdata_s = a_wdata;
        end
    end

    assign grant_s = (state_r == ST_IDLE) && grant_valid_s;

    // Next-state logic for the three-phase access sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_s = ST_SERVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SERVE: state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture on the grant edge; later changes on the request inputs are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= PORT_B;
            op_port_r    <= PORT_A;
            op_we_r      <= 1'b0;
            op_num_r     <= {AW{1'b0}};
            op_wdata_r   <= {DW{1'b0}};
        end else if (grant_s) begin
            last_grant_r <= grant_port_s;
            op_port_r    <= grant_port_s;
            op_we_r      <= sel_we_s;
            op_num_r     <= sel_num_s;
            op_wdata_r   <= sel_wdata_s;
        end else begin
            last_grant_r <= last_grant_r;
            op_port_r    <= op_port_r;
            op_we_r      <= op_we_r;
            op_num_r     <= op_num_r;
            op_wdata_r   <= op_wdata_r;
        end
    end

    // Write strobe is high only for the SERVE cycle; async reset kills an in-flight write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_r <= 1'b0;
        end else if (grant_s) begin
            rf_write_r <= sel_we_s;
        end else begin
            rf_write_r <= 1'b0;
        end
    end

    // Ack pulse for the granted port during DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_ack_r <= 1'b0;
            b_ack_r <= 1'b0;
        end else if (state_r == ST_SERVE) begin
            a_ack_r <= (op_port_r == PORT_A);
            b_ack_r <= (op_port_r == PORT_B);
        end else begin
            a_ack_r <= 1'b0;
            b_ack_r <= 1'b0;
        end
    end

    // Read data captured from the regfile at the end of SERVE, held until that port's next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rdata_r <= {DW{1'b0}};
            b_rdata_r <= {DW{1'b0}};
        end else if ((state_r == ST_SERVE) && !op_we_r) begin
            if (op_port_r == PORT_A) begin
                a_rdata_r <= rf_data_out;
                b_rdata_r <= b_rdata_r;
            end else begin
                a_rdata_r <= a_rdata_r;
                b_rdata_r <= rf_data_out;
            end
        end else begin
            a_rdata_r <= a_rdata_r;
            b_rdata_r <= b_rdata_r;
        end
    end

    // Busy mirrors "not IDLE" as a registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
        end
    end

    assign rf_writenum = op_num_r;
    assign rf_readnum  = op_num_r;
    assign rf_data_in  = op_wdata_r;
    assign rf_write    = rf_write_r;
    assign a_ack       = a_ack_r;
    assign b_ack       = b_ack_r;
    assign a_rdata     = a_rdata_r;
    assign b_rdata     = b_rdata_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: transaction-timeline reference model
// plus directed scenarios with hand-computed expectations.
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_req, a_we, b_req, b_we;
    logic [2:0]  a_num, b_num;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [15:0] a_rdata, b_rdata;
    logic [15:0] rf_data_in, rf_data_out;
    logic [2:0]  rf_writenum, rf_readnum;
    logic        rf_write, busy;

    logic [15:0] regs [8];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter #(.DW(16), .AW(3)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_num(a_num), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_num(b_num), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .rf_data_in(rf_data_in), .rf_writenum(rf_writenum), .rf_write(rf_write),
        .rf_readnum(rf_readnum), .rf_data_out(rf_data_out), .busy(busy)
    );

    // Regfile: combinational read, write on rising edge, no reset.
    assign rf_data_out = regs[rf_readnum];
    always @(posedge clk) if (rf_write) regs[rf_writenum] <= rf_data_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each grant edge g opens a 3-edge window; commit at g+1, ack after g+1.
    int          edge_cnt = 0;
    int          g_edge = -100;
    logic        m_port = 1'b0, m_we = 1'b0, m_last = 1'b1;
    logic [2:0]  m_num = 3'd0;
    logic [15:0] m_wdata = 16'h0;
    logic [15:0] m_mem [8];
    logic [15:0] m_rdata [2];

    initial begin
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
        m_rdata[0] = 16'h0;
        m_rdata[1] = 16'h0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                g_edge = -100;
                m_last = 1'b1;
                m_rdata[0] = 16'h0;
                m_rdata[1] = 16'h0;
            end else begin
                edge_cnt++;
                if (edge_cnt == g_edge + 1) begin
                    if (m_we) m_mem[m_num] = m_wdata;
                    else m_rdata[m_port] = m_mem[m_num];
                end
                if (edge_cnt >= g_edge + 3 && (a_req || b_req)) begin
                    m_port  = (a_req && b_req) ? ~m_last : b_req;
                    m_we    = m_port ? b_we : a_we;
                    m_num   = m_port ? b_num : a_num;
                    m_wdata = m_port ? b_wdata : a_wdata;
                    m_last  = m_port;
                    g_edge  = edge_cnt;
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_rf_write", {31'd0, rf_write}, 32'd0);
                check("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
                check("rst_rdata", {a_rdata, b_rdata}, 32'd0);
            end else begin
                d = edge_cnt - g_edge;
                check("busy", {31'd0, busy}, {31'd0, (d <= 1)});
                check("a_ack", {31'd0, a_ack}, {31'd0, (d == 1) && !m_port});
                check("b_ack", {31'd0, b_ack}, {31'd0, (d == 1) && m_port});
                check("rf_write", {31'd0, rf_write}, {31'd0, (d == 0) && m_we});
                check("a_rdata", {16'd0, a_rdata}, {16'd0, m_rdata[0]});
                check("b_rdata", {16'd0, b_rdata}, {16'd0, m_rdata[1]});
                check("ack_overlap", {31'd0, a_ack && b_ack}, 32'd0);
                if (d == 0) begin
                    check("rf_nums", {26'd0, rf_writenum, rf_readnum}, {26'd0, m_num, m_num});
                    check("rf_data_in", {16'd0, rf_data_in}, {16'd0, m_wdata});
                end
            end
        end
    end

    int order_q [$];
    int ack_edge_q [$];

    task automatic do_txn(input logic port, input logic we, input logic [2:0] num,
                          input logic [15:0] wdata, input logic corrupt,
                          output logic [15:0] rdata, output int lat);
        logic got;
        lat = 0;
        got = 1'b0;
        if (port) begin b_req = 1'b1; b_we = we; b_num = num; b_wdata = wdata; end
        else      begin a_req = 1'b1; a_we = we; a_num = num; a_wdata = wdata; end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            lat++;
            if (corrupt && lat == 1) begin
                if (port) begin b_wdata = 16'hFFFF; b_num = ~num; end
                else      begin a_wdata = 16'hFFFF; a_num = ~num; end
            end
            got = port ? b_ack : a_ack;
            if (got) break;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout: port %0d got no ack expected ack within 15 cycles", port);
        end
        order_q.push_back(int'(port));
        ack_edge_q.push_back(edge_cnt);
        rdata = port ? b_rdata : a_rdata;
        if (port) b_req = 1'b0; else a_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] rd, rd2;
    int lat, lat2;
    int exp_order [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        a_req = 1'b0; a_we = 1'b0; a_num = 3'd0; a_wdata = 16'h0;
        b_req = 1'b0; b_we = 1'b0; b_num = 3'd0; b_wdata = 16'h0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rf_nums", {23'd0, rf_writenum, rf_readnum, rf_write}, 32'd0);
        check("reset_rf_data_in", {16'd0, rf_data_in}, 32'd0);
        reset = 1'b0;

        // 1: A writes R0, A reads R0
        do_txn(1'b0, 1'b1, 3'd0, 16'h0003, 1'b0, rd, lat);
        check("t1_wr_latency", lat, 32'd2);
        idle(1);
        do_txn(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, rd, lat);
        check("t1_rd_latency", lat, 32'd2);
        check("t1_rdata", {16'd0, rd}, 32'h0003);

        // 2: B writes R7, A reads R7
        idle(1);
        do_txn(1'b1, 1'b1, 3'd7, 16'h000F, 1'b0, rd, lat);
        idle(1);
        do_txn(1'b0, 1'b0, 3'd7, 16'h0000, 1'b0, rd, lat);
        check("t2_rdata", {16'd0, rd}, 32'h000F);

        // 3: both requesting out of reset; A wins first
        @(negedge clk);
        reset = 1'b1;
        order_q.delete();
        fork
            do_txn(1'b0, 1'b1, 3'd1, 16'h8003, 1'b0, rd, lat);
            do_txn(1'b1, 1'b0, 3'd1, 16'h0000, 1'b0, rd2, lat2);
            begin idle(2); reset = 1'b0; end
        join
        check("t3_first_port", order_q[0], 32'd0);
        check("t3_second_port", order_q[1], 32'd1);
        check("t3_b_rdata", {16'd0, rd2}, 32'h8003);

        // 4: both ports hold req for 4 transactions each
        idle(1);
        order_q.delete();
        ack_edge_q.delete();
        fork
            begin
                logic [15:0] r1;
                int l1;
                for (int i = 0; i < 4; i++) do_txn(1'b0, 1'b1, 3'(i), 16'hA000 + 16'(i), 1'b0, r1, l1);
            end
            begin
                logic [15:0] r2;
                int l2;
                for (int j = 0; j < 4; j++) do_txn(1'b1, 1'b1, 3'(j + 4), 16'hB000 + 16'(j), 1'b0, r2, l2);
            end
        join
        for (int k = 0; k < 8; k++) check("t4_order", order_q[k], exp_order[k]);
        for (int k = 1; k < 8; k++) check("t4_spacing", ack_edge_q[k] - ack_edge_q[k-1], 32'd3);

        // 5: wdata changed during SERVE is ignored
        idle(1);
        do_txn(1'b0, 1'b1, 3'd3, 16'h1234, 1'b1, rd, lat);
        idle(1);
        do_txn(1'b1, 1'b0, 3'd3, 16'h0000, 1'b0, rd, lat);
        check("t5_r3", {16'd0, rd}, 32'h1234);

        // 6: reset mid-SERVE aborts a B write
        idle(1);
        do_txn(1'b1, 1'b1, 3'd5, 16'h0505, 1'b0, rd, lat);
        idle(1);
        b_req = 1'b1; b_we = 1'b1; b_num = 3'd5; b_wdata = 16'hBEEF;
        @(negedge clk);
        check("t6_serve_write", {31'd0, rf_write}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6_write_dropped", {31'd0, rf_write}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        b_req = 1'b0;
        @(negedge clk);
        check("t6_no_back", {31'd0, b_ack}, 32'd0);
        reset = 1'b0;
        idle(2);
        do_txn(1'b0, 1'b0, 3'd5, 16'h0000, 1'b0, rd, lat);
        check("t6_r5", {16'd0, rd}, 32'h0505);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past time limit");
        $fatal(1, "timeout");
    end

endmodule
